// File: rtl/uart_rx_core.sv
// UART receive core: 2-flop input synchronizer plus an oversampling frame FSM.
// A frame is start, 8 data bits LSB-first, even parity, an optional CRC-8 byte
// and a stop bit. Each bit is sampled mid-bit. Every completed frame updates
// data_o and the error flags and pulses rx_int_o for one cycle.
module uart_rx_core #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  input  logic       tick_i,
  input  logic       crc_en_i,
  output logic [7:0] data_o,
  output logic       parity_err_o,
  output logic       crc_err_o,
  output logic       frame_err_o,
  output logic       busy_o,
  output logic       rx_int_o
);

  localparam int unsigned CntW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CntW-1:0] HalfLast = CntW'(OVERSAMPLE / 2 - 1);
  localparam logic [CntW-1:0] FullLast = CntW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StCrc, StStop} state_e;

  state_e          state_q, state_d;
  logic [1:0]      sync_q;
  logic            rxs;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_adv;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      crc_rx_q, crc_rx_d;
  logic            par_q, par_d;
  logic            crc_en_q, crc_en_d;
  logic [7:0]      data_q, data_d;
  logic            perr_q, perr_d;
  logic            cerr_q, cerr_d;
  logic            ferr_q, ferr_d;
  logic            rx_int_q, rx_int_d;
  logic            sample;

  // CRC-8, poly 0x07, init 0x00, data fed MSB-first.
  function automatic logic [7:0] crc8(input logic [7:0] d);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      if (c[7] ^ d[i]) c = {c[6:0], 1'b0} ^ 8'h07;
      else             c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

  assign rxs     = sync_q[1];
  // Mid-bit counter for the post-start states: wraps every OVERSAMPLE ticks.
  assign cnt_adv = !tick_i ? cnt_q : ((cnt_q == FullLast) ? '0 : cnt_q + CntW'(1));
  assign sample  = tick_i && (cnt_q == FullLast);

  // Two-flop synchronizer for the asynchronous line, idles high.
  always_ff @(posedge clk_i) begin
    if (rst_i) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], rx_i};
  end

  // Next-state and datapath decisions for the frame FSM.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    crc_rx_d = crc_rx_q;
    par_d    = par_q;
    crc_en_d = crc_en_q;
    data_d   = data_q;
    perr_d   = perr_q;
    cerr_d   = cerr_q;
    ferr_d   = ferr_q;
    rx_int_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (!rxs) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (tick_i) begin
          if (cnt_q == HalfLast) begin
            cnt_d = '0;
            if (!rxs) begin
              state_d  = StData;
              crc_en_d = crc_en_i;
              bit_d    = 3'd0;
            end else begin
              // Line went back high before mid-start: a glitch, not a frame.
              state_d = StIdle;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StData: begin
        cnt_d = cnt_adv;
        if (sample) begin
          shift_d[bit_q] = rxs;
          bit_d          = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = StParity;
        end
      end
      StParity: begin
        cnt_d = cnt_adv;
        if (sample) begin
          par_d   = rxs;
          bit_d   = 3'd0;
          state_d = crc_en_q ? StCrc : StStop;
        end
      end
      StCrc: begin
        cnt_d = cnt_adv;
        if (sample) begin
          crc_rx_d[bit_q] = rxs;
          bit_d           = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        cnt_d = cnt_adv;
        if (sample) begin
          data_d   = shift_q;
          perr_d   = par_q != (^shift_q);
          cerr_d   = crc_en_q && (crc_rx_q != crc8(shift_q));
          ferr_d   = !rxs;
          rx_int_d = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and result registers; reset aborts any frame without a pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      bit_q    <= 3'd0;
      shift_q  <= 8'h00;
      crc_rx_q <= 8'h00;
      par_q    <= 1'b0;
      crc_en_q <= 1'b0;
      data_q   <= 8'h00;
      perr_q   <= 1'b0;
      cerr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      rx_int_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      crc_rx_q <= crc_rx_d;
      par_q    <= par_d;
      crc_en_q <= crc_en_d;
      data_q   <= data_d;
      perr_q   <= perr_d;
      cerr_q   <= cerr_d;
      ferr_q   <= ferr_d;
      rx_int_q <= rx_int_d;
    end
  end

  assign data_o       = data_q;
  assign parity_err_o = perr_q;
  assign crc_err_o    = cerr_q;
  assign frame_err_o  = ferr_q;
  assign busy_o       = (state_q != StIdle);
  assign rx_int_o     = rx_int_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: a table of whole frames, then
// hand-written glitch, reset-in-CRC and back-to-back sequences.
module tb_uart_rx_core;

  localparam int unsigned Os      = 16;
  localparam int          TickDiv = 4;
  localparam int          BitClks = Os * TickDiv;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       tick = 1'b0;
  logic       crc_en = 1'b0;
  logic [7:0] data;
  logic       par_err, crc_err, frame_err, busy, rx_int;

  int total = 0;
  int bad = 0;
  int pulse_cnt = 0;
  logic [7:0] cap_data[$];
  logic [2:0] cap_flg[$];

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       ce;
    logic [7:0] c;
    logic       stop;
    logic [7:0] ed;
    logic       ep;
    logic       ec;
    logic       ef;
  } vec_t;

  vec_t vecs[6];

  uart_rx_core #(.OVERSAMPLE(Os)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .rx_i        (rx),
    .tick_i      (tick),
    .crc_en_i    (crc_en),
    .data_o      (data),
    .parity_err_o(par_err),
    .crc_err_o   (crc_err),
    .frame_err_o (frame_err),
    .busy_o      (busy),
    .rx_int_o    (rx_int)
  );

  always #5 clk = ~clk;

  initial begin
    int tc;
    tc = 0;
    forever begin
      @(negedge clk);
      tc++;
      tick = (tc % TickDiv == 0);
    end
  end

  // Every cycle with rx_int high counts, so a stretched pulse shows up as extra.
  always @(negedge clk) begin
    if (rx_int) begin
      pulse_cnt++;
      cap_data.push_back(data);
      cap_flg.push_back({par_err, crc_err, frame_err});
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    clks(BitClks);
  endtask

  // Low stop bit is held 48 clocks: past the stop sample, short of the
  // recovery START's mid-bit check, which then sees a high line.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic has_crc,
                            input logic [7:0] c, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    if (has_crc) for (int i = 0; i < 8; i++) send_bit(c[i]);
    if (stop) begin
      send_bit(1'b1);
    end else begin
      rx = 1'b0;
      clks(48);
      rx = 1'b1;
      clks(BitClks * 2);
    end
  endtask

  initial begin
    int p0;
    logic [7:0] d0;

    //        d      p     ce    crc    stop  exp_d  ep    ec    ef
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h01, 1'b1, 1'b1, 8'h07, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{8'h80, 1'b1, 1'b1, 8'h89, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h01, 1'b1, 1'b1, 8'h06, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{8'h01, 1'b1, 1'b0, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0, 1'b1};

    clks(5);
    rst = 1'b0;
    clks(2);
    chk("reset data", data, 8'h00);
    chk("reset parity_err", par_err, 0);
    chk("reset crc_err", crc_err, 0);
    chk("reset frame_err", frame_err, 0);
    chk("reset busy", busy, 0);
    chk("reset rx_int", rx_int, 0);

    for (int i = 0; i < 6; i++) begin
      crc_en = vecs[i].ce;
      p0 = pulse_cnt;
      send_frame(vecs[i].d, vecs[i].p, vecs[i].ce, vecs[i].c, vecs[i].stop);
      clks(BitClks);
      chk($sformatf("vec%0d pulses", i), pulse_cnt, p0 + 1);
      chk($sformatf("vec%0d data", i), data, vecs[i].ed);
      chk($sformatf("vec%0d parity_err", i), par_err, vecs[i].ep);
      chk($sformatf("vec%0d crc_err", i), crc_err, vecs[i].ec);
      chk($sformatf("vec%0d frame_err", i), frame_err, vecs[i].ef);
      chk($sformatf("vec%0d busy", i), busy, 0);
    end

    // Glitch: 5 ticks low. Also checks the 3-cycle start-edge latency.
    crc_en = 1'b0;
    p0 = pulse_cnt;
    d0 = data;
    rx = 1'b0;
    clks(2);
    chk("edge latency busy@2", busy, 0);
    clks(1);
    chk("edge latency busy@3", busy, 1);
    clks(5 * TickDiv - 3);
    rx = 1'b1;
    clks(BitClks * 2);
    chk("glitch busy", busy, 0);
    chk("glitch pulses", pulse_cnt, p0);
    chk("glitch data held", data, d0);
    chk("glitch frame_err held", frame_err, 1);

    // Abort in the CRC state: after start, data, parity and two CRC bits.
    crc_en = 1'b1;
    p0 = pulse_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    rx = 1'b1;
    chk("pre-reset busy", busy, 1);
    rst = 1'b1;
    clks(1);
    rst = 1'b0;
    chk("rst mid busy", busy, 0);
    chk("rst mid data", data, 8'h00);
    chk("rst mid frame_err", frame_err, 0);
    clks(BitClks * 2);
    chk("rst mid pulses", pulse_cnt, p0);
    chk("rst mid rx_int", rx_int, 0);
    chk("rst mid parity_err", par_err, 0);
    chk("rst mid crc_err", crc_err, 0);

    crc_en = 1'b0;
    p0 = pulse_cnt;
    send_frame(8'h5A, 1'b0, 1'b0, 8'h00, 1'b1);
    clks(BitClks);
    chk("post-reset pulses", pulse_cnt, p0 + 1);
    chk("post-reset data", data, 8'h5A);
    chk("post-reset flags", {par_err, crc_err, frame_err}, 3'b000);

    // Back-to-back: 0x3C with CRC (crc_en dropped mid-frame), then 0xC3 without.
    crc_en = 1'b1;
    p0 = pulse_cnt;
    fork
      send_frame(8'h3C, 1'b0, 1'b1, 8'hB4, 1'b1);
      begin
        clks(BitClks * 5);
        crc_en = 1'b0;
      end
    join
    send_frame(8'hC3, 1'b0, 1'b0, 8'h00, 1'b1);
    clks(BitClks);
    chk("b2b pulses", pulse_cnt, p0 + 2);
    if (cap_data.size() >= p0 + 2) begin
      chk("b2b first data", cap_data[p0], 8'h3C);
      chk("b2b first flags", cap_flg[p0], 3'b000);
      chk("b2b second data", cap_data[p0 + 1], 8'hC3);
      chk("b2b second flags", cap_flg[p0 + 1], 3'b000);
    end
    chk("final busy", busy, 0);
    chk("final rx_int", rx_int, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
